audio_out_mixer: RTL

Parametrised successor to the board-level audio output path. It mixes NUM_VOICES signed synth voices with per-voice pan and a master attenuation, and saturates the result. Mixed stereo frames are buffered in a DEPTH-entry FIFO and drained to the Audio_Controller write interface under its audio_out_allowed handshake. Test-tone and mute modes replace the old switch-driven square wave. The block sits between the synth voice generators and Audio_Controller.

---
 rtl/audio_out_mixer.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/audio_out_mixer.sv
`default_nettype none
// ============================================================================
//  Module   : audio_out_mixer
//  Brief    : Pan/attenuate/saturate voice mixer with stereo frame FIFO and
//             test-tone / mute sources feeding the Audio_Controller writer.
//  Revision : 1.0 - initial release
// ============================================================================
module audio_out_mixer #(
    parameter int          NUM_VOICES = 4,
    parameter int          SAMPLE_W   = 16,
    parameter int          DEPTH      = 8,
    parameter logic [31:0] TONE_AMP   = 32'd10000000
) (
    input  logic                           CLOCK_50,
    input  logic                           resetn,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] in_samples,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_VOICES-1:0]          voice_en,
    input  logic [2*NUM_VOICES-1:0]        voice_pan,
    input  logic [2:0]                     master_shift,
    input  logic [1:0]                     mode,
    input  logic [19:0]                    tone_period,
    input  logic                           audio_out_allowed,
    output logic                           write_audio_out,
    output logic [31:0]                    left_channel_audio_out,
    output logic [31:0]                    right_channel_audio_out,
    output logic [$clog2(DEPTH):0]         fifo_level,
    output logic                           underrun,
    input  logic                           clear_flags
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;
    localparam int c_ACC_W = SAMPLE_W + $clog2(NUM_VOICES) + 1;
    localparam int c_EXT_W = c_ACC_W - SAMPLE_W;

    localparam logic signed [c_ACC_W-1:0] c_SAT_MAX = {{(c_EXT_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [c_ACC_W-1:0] c_SAT_MIN = {{(c_EXT_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = {{(c_PTR_W-1){1'b0}}, 1'b1};
    localparam logic [c_LVL_W-1:0] c_LVL_ONE   = {{(c_LVL_W-1){1'b0}}, 1'b1};
    localparam logic [c_LVL_W:0]   c_OCC_LIMIT = (c_LVL_W+1)'(DEPTH);
    localparam logic [19:0]        c_CNT_ONE   = 20'd1;

    localparam logic [1:0] c_MODE_MIX  = 2'd0;
    localparam logic [1:0] c_MODE_TONE = 2'd1;

    // Saturate to the signed sample range, then left-justify into 32 bits.
    function automatic logic [31:0] sat_pack(input logic signed [c_ACC_W-1:0] v);
        logic [SAMPLE_W-1:0] s;
        if (v > c_SAT_MAX) begin
            s = c_SAT_MAX[SAMPLE_W-1:0];
        end else if (v < c_SAT_MIN) begin
            s = c_SAT_MIN[SAMPLE_W-1:0];
        end else begin
            s = v[SAMPLE_W-1:0];
        end
        return 32'(s) << (32 - SAMPLE_W);
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]          r_mode;
    logic                r_mix_valid;
    logic [31:0]         r_mix_l;
    logic [31:0]         r_mix_r;
    logic [31:0]         r_fifo_l [DEPTH];
    logic [31:0]         r_fifo_r [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_LVL_W-1:0]  r_count;
    logic                r_in_ready;
    logic                r_write;
    logic [31:0]         r_left;
    logic [31:0]         r_right;
    logic                r_underrun;
    logic [19:0]         r_tone_cnt;
    logic                r_phase;

    // ------------------------------------------------------------------
    // Mixer datapath
    // ------------------------------------------------------------------
    logic signed [SAMPLE_W-1:0] w_voice [NUM_VOICES];
    logic signed [c_ACC_W-1:0]  w_sum_l;
    logic signed [c_ACC_W-1:0]  w_sum_r;
    logic signed [c_ACC_W-1:0]  w_att_l;
    logic signed [c_ACC_W-1:0]  w_att_r;
    logic [31:0]                w_mix_l;
    logic [31:0]                w_mix_r;

    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
        assign w_voice[gi] = in_samples[gi*SAMPLE_W +: SAMPLE_W];
    end

    always_comb begin
        w_sum_l = '0;
        w_sum_r = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (voice_en[i] && voice_pan[2*i]) begin
                w_sum_l = w_sum_l + {{c_EXT_W{w_voice[i][SAMPLE_W-1]}}, w_voice[i]};
            end
            if (voice_en[i] && voice_pan[2*i+1]) begin
                w_sum_r = w_sum_r + {{c_EXT_W{w_voice[i][SAMPLE_W-1]}}, w_voice[i]};
            end
        end
        w_att_l = w_sum_l >>> master_shift;
        w_att_r = w_sum_r >>> master_shift;
        w_mix_l = sat_pack(w_att_l);
        w_mix_r = sat_pack(w_att_r);
    end

    // ------------------------------------------------------------------
    // Flow control and output selection
    // ------------------------------------------------------------------
    logic               w_mode_chg;
    logic               w_mix_run;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_strobe_ok;
    logic               w_underrun_set;
    logic [c_LVL_W-1:0] w_count_nxt;
    logic [c_LVL_W:0]   w_occ_nxt;
    logic               w_in_ready_nxt;
    logic               w_write_nxt;
    logic [31:0]        w_tone_sample;
    logic [31:0]        w_out_l;
    logic [31:0]        w_out_r;

    always_comb begin
        w_mode_chg     = (mode != r_mode);
        w_mix_run      = (r_mode == c_MODE_MIX) && !w_mode_chg;
        w_accept       = in_valid && r_in_ready && w_mix_run;
        w_push         = r_mix_valid && w_mix_run;
        w_pop          = w_mix_run && (r_count != '0) && audio_out_allowed && !r_write;
        w_strobe_ok    = audio_out_allowed && !r_write && !w_mode_chg;
        w_underrun_set = w_mix_run && audio_out_allowed && (r_count == '0) && !r_mix_valid;

        if (w_mode_chg) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + c_LVL_ONE;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - c_LVL_ONE;
        end else begin
            w_count_nxt = r_count;
        end

        // in_ready is registered: it is computed from next-cycle occupancy.
        w_occ_nxt      = {1'b0, w_count_nxt} + {{c_LVL_W{1'b0}}, w_accept};
        w_in_ready_nxt = (mode == c_MODE_MIX) && (w_occ_nxt < c_OCC_LIMIT);

        w_tone_sample = '0;
        if (tone_period != '0) begin
            w_tone_sample = r_phase ? (~TONE_AMP + 32'd1) : TONE_AMP;
        end

        case (r_mode)
            c_MODE_MIX: begin
                w_write_nxt = w_pop;
                w_out_l     = r_fifo_l[r_rd_ptr];
                w_out_r     = r_fifo_r[r_rd_ptr];
            end
            c_MODE_TONE: begin
                w_write_nxt = w_strobe_ok;
                w_out_l     = w_tone_sample;
                w_out_r     = w_tone_sample;
            end
            default: begin
                w_write_nxt = w_strobe_ok;
                w_out_l     = '0;
                w_out_r     = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control / output registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_mode      <= c_MODE_MIX;
            r_mix_valid <= 1'b0;
            r_mix_l     <= '0;
            r_mix_r     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b0;
            r_write     <= 1'b0;
            r_left      <= '0;
            r_right     <= '0;
            r_underrun  <= 1'b0;
        end else begin
            r_mode      <= mode;
            r_mix_valid <= w_accept;
            if (w_accept) begin
                r_mix_l <= w_mix_l;
                r_mix_r <= w_mix_r;
            end
            r_count <= w_count_nxt;
            if (w_mode_chg) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                end
            end
            r_in_ready <= w_in_ready_nxt;
            r_write    <= w_write_nxt;
            if (w_write_nxt) begin
                r_left  <= w_out_l;
                r_right <= w_out_r;
            end
            if (w_underrun_set) begin
                r_underrun <= 1'b1;
            end else if (clear_flags) begin
                r_underrun <= 1'b0;
            end
        end
    end

    // Frame storage carries no reset; occupancy is tracked by r_count.
    always_ff @(posedge CLOCK_50) begin
        if (w_push) begin
            r_fifo_l[r_wr_ptr] <= r_mix_l;
            r_fifo_r[r_wr_ptr] <= r_mix_r;
        end
    end

    // ------------------------------------------------------------------
    // Test-tone generator
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_tone_cnt <= '0;
            r_phase    <= 1'b0;
        end else if (w_mode_chg) begin
            r_tone_cnt <= '0;
            r_phase    <= 1'b0;
        end else if (r_mode == c_MODE_TONE) begin
            if (tone_period == '0) begin
                r_tone_cnt <= '0;
            end else if (r_tone_cnt >= tone_period) begin
                r_tone_cnt <= '0;
                r_phase    <= ~r_phase;
            end else begin
                r_tone_cnt <= r_tone_cnt + c_CNT_ONE;
            end
        end
    end

    assign in_ready                = r_in_ready;
    assign write_audio_out         = r_write;
    assign left_channel_audio_out  = r_left;
    assign right_channel_audio_out = r_right;
    assign fifo_level              = r_count;
    assign underrun                = r_underrun;

endmodule
`default_nettype wire
